// File: rtl/output_display_driver_if.sv
// Load/data request bus and seven-segment display outputs of output_display_driver.
interface output_display_driver_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DIGITS     = 8
);
    logic                    load;
    logic [DATA_WIDTH-1:0]   datain;
    logic [7*DIGITS-1:0]     hex;
    logic                    busy;
    logic                    done;
    logic                    overflow;

    modport master (output load, datain, input hex, busy, done, overflow);
    modport slave  (input load, datain, output hex, busy, done, overflow);
endinterface

// File: rtl/output_display_driver.sv
// Binary-to-decimal seven-segment driver: sequential double-dabble conversion,
// one-deep pending buffer, leading-zero blanking and overflow dashes.
module output_display_driver #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DIGITS     = 8,
    parameter bit          BLANK      = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    output_display_driver_if.slave   bus
);
    localparam int unsigned NIB   = DATA_WIDTH / 3 + 1;
    localparam int unsigned BCD_W = 4 * NIB;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int unsigned NMAX  = (NIB > DIGITS) ? NIB : DIGITS;
    localparam int unsigned EXT_W = 4 * NMAX;
    localparam int unsigned HEX_W = 7 * DIGITS;
    localparam logic [6:0]  SEG_DASH  = 7'b0111111;
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

    state_t                  state, state_n;
    logic [DATA_WIDTH-1:0]   shift_q, shift_n;
    logic [BCD_W-1:0]        bcd_q, bcd_n, adj;
    logic [CNT_W-1:0]        cnt_q, cnt_n;
    logic [DATA_WIDTH-1:0]   pend_q, pend_n;
    logic                    pendv_q, pendv_n;
    logic [HEX_W-1:0]        hex_q, hex_n, hex_c;
    logic                    ovf_q, ovf_n, ovf_c;
    logic                    busy_q, busy_n;
    logic                    done_q, done_n;
    logic [EXT_W-1:0]        bcd_ext;
    logic [3:0]              nib;
    logic                    seen;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Display image of the finished BCD value; scanned from the top so blanking
    // stops at the most significant non-zero digit.
    always_comb begin
        bcd_ext = EXT_W'(bcd_q);
        ovf_c   = 1'b0;
        seen    = 1'b0;
        nib     = 4'd0;
        hex_c   = '1;
        for (int unsigned i = DIGITS; i < NMAX; i++)
            ovf_c = ovf_c | (bcd_ext[4*i +: 4] != 4'd0);
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            nib  = bcd_ext[4*k +: 4];
            seen = seen | (nib != 4'd0) | (k == 0);
            if (ovf_c)
                hex_c[7*k +: 7] = SEG_DASH;
            else if (BLANK && !seen)
                hex_c[7*k +: 7] = SEG_BLANK;
            else
                hex_c[7*k +: 7] = seg7(nib);
        end
    end

    // Next-state and datapath
    always_comb begin
        state_n = state;
        shift_n = shift_q;
        bcd_n   = bcd_q;
        cnt_n   = cnt_q;
        pend_n  = pend_q;
        pendv_n = pendv_q;
        hex_n   = hex_q;
        ovf_n   = ovf_q;
        done_n  = 1'b0;
        adj     = bcd_q;
        for (int unsigned i = 0; i < NIB; i++)
            if (adj[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;

        case (state)
            IDLE: begin
                if (bus.load) begin
                    shift_n = bus.datain;
                    bcd_n   = '0;
                    cnt_n   = '0;
                    state_n = CONVERT;
                end
            end
            CONVERT: begin
                if (bus.load) begin
                    pend_n  = bus.datain;
                    pendv_n = 1'b1;
                end
                {bcd_n, shift_n} = {adj, shift_q} << 1;
                cnt_n = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_WIDTH - 1))
                    state_n = UPDATE;
            end
            UPDATE: begin
                hex_n  = hex_c;
                ovf_n  = ovf_c;
                done_n = 1'b1;
                // A load arriving on this very edge is the newest value, so it wins.
                if (bus.load || pendv_q) begin
                    shift_n = bus.load ? bus.datain : pend_q;
                    pendv_n = 1'b0;
                    bcd_n   = '0;
                    cnt_n   = '0;
                    state_n = CONVERT;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= '0;
            pendv_q <= 1'b0;
            hex_q   <= '1;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            shift_q <= shift_n;
            bcd_q   <= bcd_n;
            cnt_q   <= cnt_n;
            pend_q  <= pend_n;
            pendv_q <= pendv_n;
            hex_q   <= hex_n;
            ovf_q   <= ovf_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    assign bus.hex      = hex_q;
    assign bus.overflow = ovf_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_output_display_driver.sv
// Bench for output_display_driver: two instances (8 digits blanked, 10 digits unblanked)
// driven in lockstep and compared against a decimal-arithmetic display model.
module tb_output_display_driver;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    output_display_driver_if #(.DATA_WIDTH(32), .DIGITS(8))  b0 ();
    output_display_driver_if #(.DATA_WIDTH(32), .DIGITS(10)) b1 ();

    output_display_driver #(.DATA_WIDTH(32), .DIGITS(8),  .BLANK(1'b1)) u0 (
        .clock(clock), .reset(reset), .bus(b0.slave));
    output_display_driver #(.DATA_WIDTH(32), .DIGITS(10), .BLANK(1'b0)) u1 (
        .clock(clock), .reset(reset), .bus(b1.slave));

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // Expected display from decimal digits obtained by repeated division.
    function automatic logic [69:0] model_hex(input longint unsigned v, input int digits,
                                              input bit blank, output bit ovf);
        logic [69:0] h;
        int d [11];
        int msd;
        longint unsigned t;
        h   = '1;
        t   = v;
        msd = 0;
        for (int i = 0; i < 11; i++) begin
            d[i] = int'(t % 10);
            t    = t / 10;
            if (d[i] != 0) msd = i;
        end
        ovf = (msd >= digits);
        for (int k = 0; k < digits; k++) begin
            if (ovf)                    h[7*k +: 7] = 7'b0111111;
            else if (blank && k > msd)  h[7*k +: 7] = 7'b1111111;
            else                        h[7*k +: 7] = seg_tab[d[k]];
        end
        return h;
    endfunction

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic [31:0] v);
        b0.load = ld; b0.datain = v;
        b1.load = ld; b1.datain = v;
    endtask

    task automatic check_display(input string tag, input logic [31:0] v);
        logic [69:0] e0, e1;
        bit o0, o1;
        e0 = model_hex(longint'(v), 8, 1'b1, o0);
        e1 = model_hex(longint'(v), 10, 1'b0, o1);
        chk({tag, "_hex8"},  70'(b0.hex), 70'(e0[55:0]));
        chk({tag, "_ovf8"},  70'(b0.overflow), 70'(o0));
        chk({tag, "_hex10"}, 70'(b1.hex), e1);
        chk({tag, "_ovf10"}, 70'(b1.overflow), 70'(o1));
    endtask

    // Single load from idle; checks latency, busy length, display and pulse width.
    task automatic run(input string tag, input logic [31:0] v);
        int lat, bcnt;
        @(negedge clock); drive(1'b1, v);
        @(negedge clock); drive(1'b0, '0);
        lat = 0; bcnt = 0;
        while (!b0.done && lat < 100) begin
            if (b0.busy) bcnt++;
            @(negedge clock); lat++;
        end
        chk({tag, "_latency"}, 70'(lat), 70'(33));
        chk({tag, "_busy_cycles"}, 70'(bcnt), 70'(33));
        chk({tag, "_busy_end"}, 70'(b0.busy), 70'(0));
        chk({tag, "_done10"}, 70'(b1.done), 70'(1));
        check_display(tag, v);
        @(negedge clock);
        chk({tag, "_done_pulse"}, 70'(b0.done), 70'(0));
    endtask

    initial begin
        int lat, first, second, ndone, busy_low, dseen;
        logic [31:0] v;
        drive(1'b0, '0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("rst_hex8", 70'(b0.hex), 70'({56{1'b1}}));
        chk("rst_hex10", 70'(b1.hex), {70{1'b1}});
        chk("rst_flags", 70'({b0.busy, b0.done, b0.overflow}), 70'(0));

        run("zero", 32'd0);
        run("d12345678", 32'd12345678);
        run("ovf", 32'd100000000);
        run("seven", 32'd7);

        // Pending buffer: 42 is superseded by 77 before the first conversion ends.
        @(negedge clock); drive(1'b1, 32'd5);
        @(negedge clock); drive(1'b0, '0);
        lat = 0; first = -1; second = -1; ndone = 0; busy_low = 0;
        while (lat < 72) begin
            if (b0.done) begin
                ndone++;
                if (first < 0) begin
                    first = lat;
                    check_display("pend_first", 32'd5);
                end else begin
                    second = lat;
                    check_display("pend_second", 32'd77);
                end
            end
            if (first >= 0 && second < 0 && !b0.busy) busy_low++;
            if (lat == 3)       drive(1'b1, 32'd42);
            else if (lat == 10) drive(1'b1, 32'd77);
            else                drive(1'b0, '0);
            @(negedge clock); lat++;
        end
        chk("pend_first_lat", 70'(first), 70'(33));
        chk("pend_gap", 70'(second - first), 70'(33));
        chk("pend_ndone", 70'(ndone), 70'(2));
        chk("pend_busy_gap", 70'(busy_low), 70'(0));

        // Reset during conversion aborts it silently.
        @(negedge clock); drive(1'b1, 32'd999);
        @(negedge clock); drive(1'b0, '0);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        chk("abort_busy", 70'(b0.busy), 70'(0));
        chk("abort_hex8", 70'(b0.hex), 70'({56{1'b1}}));
        chk("abort_hex10", 70'(b1.hex), {70{1'b1}});
        dseen = 0;
        repeat (40) begin
            if (b0.done || b1.done) dseen++;
            @(negedge clock);
        end
        chk("abort_no_done", 70'(dseen), 70'(0));
        run("one", 32'd1);

        run("max", 32'hFFFF_FFFF);
        run("twelve", 32'd12);

        for (int i = 0; i < 10; i++) begin
            v = $urandom;
            if (i % 3 == 0) v = v % 1000;
            else if (i % 3 == 1) v = v % 100000000;
            run("rand", v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/output_display_driver.md
Name: output_display_driver

Overview:
Sits directly downstream of the memory-mapped output register block and consumes its 32-bit dataout word. On each load strobe it converts the captured unsigned binary value to decimal using a sequential double-dabble (shift-add-3) engine. It then drives DIGITS active-low seven-segment displays, one per decimal digit, as on the board's HEX outputs. A one-deep pending buffer lets a new value arrive while a conversion is in progress.

Parameters:
DATA_WIDTH, 32, width of the binary input word.
DIGITS, 8, number of seven-segment digits driven; digit 0 is least significant.
BLANK, 1, 1 = blank leading zeros (digit 0 is always shown); 0 = show all zeros.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
load  input  1  request to display datain; sampled on each rising clock edge.
datain  input  DATA_WIDTH  unsigned value, taken from the output block's dataout.
hex  output  7*DIGITS  segments; digit k at bits [7k+6:7k], order {g,f,e,d,c,b,a}, active-low.
busy  output  1  high while a conversion is in progress or pending.
done  output  1  one-cycle pulse when hex takes a new value.
overflow  output  1  high when the displayed value needs more than DIGITS digits.

Behaviour:
- Clock and reset: one clock, named clock; reset is synchronous and active-high.
- Reset values:
  - hex: all digits 7'b1111111 (blank).
  - busy, done, overflow: 0.
  - pending flag cleared; FSM in IDLE.
  - Reset mid-conversion aborts it: no done pulse, hex goes blank.
- FSM states: IDLE, CONVERT, UPDATE.
- IDLE:
  - load=1 captures datain into the shift register.
  - Clears the BCD register (4*(DATA_WIDTH/3+1) bits) and bit counter.
  - Next state CONVERT; busy=1 from the next cycle.
- CONVERT: exactly DATA_WIDTH cycles. Each cycle, every BCD nibble >=5 gets +3, then {bcd, shift} shifts left by 1. Then go to UPDATE.
- UPDATE: lasts one cycle and registers hex, overflow and done=1.
  - overflow=1 if any BCD nibble at index >= DIGITS is non-zero. All digits then show dash 7'b0111111.
  - Otherwise each digit is encoded from its nibble (active-low):
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
    - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - BLANK=1: digits above the most significant non-zero digit show 1111111. Digit 0 is always shown, so value 0 displays "0".
- Latency: with load sampled at edge N, new hex, done=1 and busy=0 (if nothing is pending) are visible after edge N+DATA_WIDTH+1.
- Pending buffer:
  - load=1 during CONVERT or UPDATE stores datain in the pending register and sets pending.
  - A later load overwrites it, so only the latest value is kept.
- Leaving UPDATE:
  - With pending set: capture the pending value, clear pending, go straight to CONVERT. busy stays 1; done still pulses for the completed value.
  - Otherwise go to IDLE.
- hex holds its value between updates; it never shows intermediate BCD.

Test Plan:
1. Reset, then load with datain=0 (BLANK=1, DATA_WIDTH=32) -> done pulse after edge N+33; hex[6:0]=1000000, other digits 1111111; overflow=0.
2. load datain=12345678 -> digits 7..0 show 1,2,3,4,5,6,7,8 (digit0=0000000); one done pulse; busy high for exactly 33 cycles.
3. load datain=100000000 -> overflow=1; all 8 digits 0111111. Then load 7 -> overflow=0; digit0=1111000, others blank.
4. load 5, then load 42 at cycle 3 and 77 at cycle 10 while busy:
   - first done shows 5 (digit0=0010010);
   - second done, 33 cycles later, shows 77;
   - 42 is never displayed; busy stays high continuously between the two done pulses.
5. load 999 and assert reset at cycle 10 of CONVERT -> busy=0, done never pulses, hex all 1111111. A following load 1 displays "1" normally.
6. DIGITS=10, BLANK=0, load 4294967295 -> digits 9..0 show 4,2,9,4,9,6,7,2,9,5; overflow=0. Load 12 -> digits 9..2 show 1000000 (zeros not blanked).
